// File: rtl/mem_port_arbiter_if.sv
// Bundle joining the IF/MEM request sides, the arbiter and the single shared memory port.
// slave = arbiter side; master = pipeline stages plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one fixed-latency memory port.
// Define ARB_FAIR_EN to alternate ties between requesters; otherwise dm always wins ties.
module mem_port_arbiter #(
    parameter int unsigned AW  = 9,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          if_valid_q, dm_valid_q;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          op_we_q;
    logic          if_ok, dm_ok, dm_wins;
    logic          grant_if, grant_dm, done;

    // A requester completing this cycle is masked; reset keeps the port quiet.
    assign if_ok = rst_n & bus.if_req & ~if_valid_q;
    assign dm_ok = rst_n & bus.dm_req & ~dm_valid_q;

`ifdef ARB_FAIR_EN
    logic last_dm_q;

    assign dm_wins = dm_ok & (~if_ok | ~last_dm_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dm_q <= 1'b0;
        end else if (grant_dm) begin
            last_dm_q <= 1'b1;
        end else if (grant_if) begin
            last_dm_q <= 1'b0;
        end
    end
`else
    assign dm_wins = dm_ok;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_wins) begin
                    grant_dm = 1'b1;
                    cnt_d    = CW'(LAT);
                    state_d  = BUSY_DM;
                end else if (if_ok) begin
                    grant_if = 1'b1;
                    cnt_d    = CW'(LAT);
                    state_d  = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                cnt_d = cnt_q - CW'(1);
                // Last latency cycle: rdata is on the port, capture and release.
                if (cnt_q == CW'(1)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = grant_if | grant_dm;
    assign bus.mem_we    = grant_dm & bus.dm_we;
    assign bus.mem_addr  = grant_dm ? bus.dm_addr : (grant_if ? bus.if_addr : '0);
    assign bus.mem_wdata = (grant_dm & bus.dm_we) ? bus.dm_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            op_we_q    <= 1'b0;
        end else begin
            if_valid_q <= done & (state_q == BUSY_IF);
            dm_valid_q <= done & (state_q == BUSY_DM);
            if (grant_dm) begin
                op_we_q <= bus.dm_we;
            end
            if (done && state_q == BUSY_IF) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (done && state_q == BUSY_DM) begin
                dm_rdata_q <= op_we_q ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.dm_req & ~dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on LAT=1 and LAT=3 instances plus a
// randomized run against a cycle-count reference model of the shared port.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n1, rst_n3;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mem1 [MW];
    logic [DW-1:0] mem3 [MW];
    logic [DW-1:0] ref_mem [MW];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(b1));
    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n3), .bus(b3));

    always #5 clk = ~clk;

    // Memory behind the LAT=1 port: data for an issue at t appears during t+1, junk otherwise.
    initial begin : resp1
        logic e, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        b1.mem_rdata = '0;
        forever begin
            @(negedge clk);
            e = b1.mem_en; w = b1.mem_we; a = b1.mem_addr; d = b1.mem_wdata;
            @(posedge clk); #1;
            if (e === 1'b1 && w === 1'b1) mem1[a] = d;
            b1.mem_rdata = (e === 1'b1 && w !== 1'b1) ? mem1[a] : $urandom();
        end
    end

    // Memory behind the LAT=3 port: three-deep delay line of read issues.
    initial begin : resp3
        logic e, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic v [3];
        logic [AW-1:0] pa [3];
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; pa[i] = '0; end
        b3.mem_rdata = '0;
        forever begin
            @(negedge clk);
            e = b3.mem_en; w = b3.mem_we; a = b3.mem_addr; d = b3.mem_wdata;
            @(posedge clk); #1;
            if (e === 1'b1 && w === 1'b1) mem3[a] = d;
            for (int i = 2; i > 0; i--) begin v[i] = v[i-1]; pa[i] = pa[i-1]; end
            v[0] = (e === 1'b1) && (w !== 1'b1);
            pa[0] = a;
            b3.mem_rdata = v[2] ? mem3[pa[2]] : $urandom();
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle1();
        b1.if_req = 1'b0; b1.if_addr = '0;
        b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    endtask

    task automatic idle3();
        b3.if_req = 1'b0; b3.if_addr = '0;
        b3.dm_req = 1'b0; b3.dm_we = 1'b0; b3.dm_addr = '0; b3.dm_wdata = '0;
    endtask

    task automatic pulse_reset1();
        idle1();
        next_cycle(); rst_n1 = 1'b0;
        next_cycle(); rst_n1 = 1'b1;
    endtask

    task automatic test_reset();
        logic [150:0] o1, o3;
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        b1.if_req = 1'b1; b1.if_addr = 9'h007; b1.dm_req = 1'b1; b1.dm_we = 1'b1;
        b1.dm_addr = 9'h009; b1.dm_wdata = 32'h1234_5678;
        b3.if_req = 1'b1; b3.if_addr = 9'h007; b3.dm_req = 1'b1; b3.dm_we = 1'b1;
        b3.dm_addr = 9'h009; b3.dm_wdata = 32'h1234_5678;
        next_cycle(); next_cycle();
        @(negedge clk);
        o1 = {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.if_valid, b1.dm_valid, b1.if_rdata, b1.dm_rdata};
        o3 = {b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.if_valid, b3.dm_valid, b3.if_rdata, b3.dm_rdata};
        checks++; if (o1 !== '0) begin errors++; $display("FAIL reset_outs_lat1: got %h want 0", o1); end
        checks++; if (o3 !== '0) begin errors++; $display("FAIL reset_outs_lat3: got %h want 0", o3); end
        next_cycle();
        idle1(); idle3();
        rst_n1 = 1'b1; rst_n3 = 1'b1;
        @(negedge clk);
        checks++; if (b1.mem_en !== 1'b0) begin errors++; $display("FAIL reset_idle_en: got %b want 0", b1.mem_en); end
        checks++; if (b1.stall_if !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b want 0", b1.stall_if); end
    endtask

    task automatic test_fetch();
        mem1[4] = 32'h2001_0005;
        next_cycle();
        b1.if_req = 1'b1; b1.if_addr = 9'h004;
        @(negedge clk);
        checks++; if ({b1.mem_en, b1.mem_we, b1.mem_addr} !== {1'b1, 1'b0, 9'h004})
            begin errors++; $display("FAIL fetch_issue: got en=%b we=%b a=%h want 1 0 004", b1.mem_en, b1.mem_we, b1.mem_addr); end
        checks++; if (b1.stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_t: got %b want 1", b1.stall_if); end
        next_cycle(); @(negedge clk);
        checks++; if ({b1.mem_en, b1.if_valid, b1.stall_if} !== 3'b001)
            begin errors++; $display("FAIL fetch_t1: got en/valid/stall=%b want 001", {b1.mem_en, b1.if_valid, b1.stall_if}); end
        next_cycle(); @(negedge clk);
        checks++; if (b1.if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", b1.if_valid); end
        checks++; if (b1.if_rdata !== 32'h2001_0005) begin errors++; $display("FAIL fetch_rdata: got %h want 20010005", b1.if_rdata); end
        checks++; if ({b1.stall_if, b1.mem_en} !== 2'b00) begin errors++; $display("FAIL fetch_mask: got stall/en=%b want 00", {b1.stall_if, b1.mem_en}); end
        next_cycle(); idle1(); @(negedge clk);
        checks++; if (b1.if_valid !== 1'b0) begin errors++; $display("FAIL fetch_one_shot: got %b want 0", b1.if_valid); end
    endtask

    task automatic test_write();
        int we_seen = 0;
        next_cycle();
        b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 9'h010; b1.dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== {1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF})
            begin errors++; $display("FAIL write_issue: got en=%b we=%b a=%h d=%h", b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata); end
        checks++; if (b1.stall_mem !== 1'b1) begin errors++; $display("FAIL write_stall: got %b want 1", b1.stall_mem); end
        next_cycle(); @(negedge clk);
        if (b1.mem_we !== 1'b0) we_seen++;
        next_cycle(); @(negedge clk);
        if (b1.mem_we !== 1'b0) we_seen++;
        checks++; if ({b1.dm_valid, b1.dm_rdata} !== {1'b1, 32'h0})
            begin errors++; $display("FAIL write_valid: got valid=%b rdata=%h want 1 0", b1.dm_valid, b1.dm_rdata); end
        next_cycle(); idle1();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b1.mem_we !== 1'b0) we_seen++;
            next_cycle();
        end
        checks++; if (we_seen !== 0) begin errors++; $display("FAIL write_we_once: extra mem_we cycles %0d want 0", we_seen); end
        checks++; if (mem1[9'h010] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_landed: got %h want deadbeef", mem1[9'h010]); end
    endtask

    task automatic test_both_fixed();
        pulse_reset1();
        mem1[9'h020] = 32'hAAAA_0020; mem1[9'h030] = 32'hBBBB_0030;
        next_cycle();
        b1.dm_req = 1'b1; b1.dm_addr = 9'h020; b1.if_req = 1'b1; b1.if_addr = 9'h030;
        @(negedge clk);
        checks++; if ({b1.mem_en, b1.mem_addr} !== {1'b1, 9'h020}) begin errors++; $display("FAIL both_dm_first: got en=%b a=%h want 1 020", b1.mem_en, b1.mem_addr); end
        next_cycle(); @(negedge clk);
        checks++; if (b1.mem_en !== 1'b0) begin errors++; $display("FAIL both_t1_quiet: got %b want 0", b1.mem_en); end
        next_cycle(); @(negedge clk);
        checks++; if ({b1.dm_valid, b1.dm_rdata} !== {1'b1, 32'hAAAA_0020}) begin errors++; $display("FAIL both_dm_valid: got %b %h", b1.dm_valid, b1.dm_rdata); end
        checks++; if ({b1.mem_en, b1.mem_addr} !== {1'b1, 9'h030}) begin errors++; $display("FAIL both_if_b2b: got en=%b a=%h want 1 030", b1.mem_en, b1.mem_addr); end
        next_cycle(); b1.dm_req = 1'b0; @(negedge clk);
        checks++; if ({b1.mem_en, b1.if_valid, b1.dm_valid} !== 3'b000) begin errors++; $display("FAIL both_t3: got %b want 000", {b1.mem_en, b1.if_valid, b1.dm_valid}); end
        next_cycle(); @(negedge clk);
        checks++; if ({b1.if_valid, b1.if_rdata} !== {1'b1, 32'hBBBB_0030}) begin errors++; $display("FAIL both_if_valid: got %b %h", b1.if_valid, b1.if_rdata); end
        next_cycle(); idle1();
    endtask

    task automatic test_grant_order();
        logic [AW-1:0] exp_a;
        logic exp_en;
        pulse_reset1();
        next_cycle();
        b1.dm_req = 1'b1; b1.dm_addr = 9'h040; b1.if_req = 1'b1; b1.if_addr = 9'h050;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_en = (k % 2) == 0;
            exp_a = !exp_en ? 9'h000 : ((k % 4) == 0 ? 9'h040 : 9'h050);
            checks++; if ({b1.mem_en, b1.mem_addr} !== {exp_en, exp_a})
                begin errors++; $display("FAIL order_k%0d: got en=%b a=%h want %b %h", k, b1.mem_en, b1.mem_addr, exp_en, exp_a); end
            next_cycle();
        end
        idle1();
        repeat (3) next_cycle();
    endtask

    task automatic test_fresh_tie();
        logic [AW-1:0] exp_a;
        pulse_reset1();
        next_cycle();
        b1.dm_req = 1'b1; b1.dm_addr = 9'h060;
        next_cycle(); next_cycle(); next_cycle();
        idle1();
        next_cycle();
        b1.dm_req = 1'b1; b1.dm_addr = 9'h061; b1.if_req = 1'b1; b1.if_addr = 9'h071;
`ifdef ARB_FAIR_EN
        exp_a = 9'h071;
`else
        exp_a = 9'h061;
`endif
        @(negedge clk);
        checks++; if ({b1.mem_en, b1.mem_addr} !== {1'b1, exp_a})
            begin errors++; $display("FAIL fresh_tie: got en=%b a=%h want 1 %h", b1.mem_en, b1.mem_addr, exp_a); end
        next_cycle(); idle1();
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [150:0] o3;
        int bad = 0;
        mem3[5] = 32'hCAFE_0005;
        next_cycle();
        b3.if_req = 1'b1; b3.if_addr = 9'h005;
        @(negedge clk);
        checks++; if ({b3.mem_en, b3.mem_addr} !== {1'b1, 9'h005}) begin errors++; $display("FAIL mid_issue: got en=%b a=%h", b3.mem_en, b3.mem_addr); end
        next_cycle(); rst_n3 = 1'b0;
        @(negedge clk);
        o3 = {b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.if_valid, b3.dm_valid, b3.if_rdata, b3.dm_rdata};
        checks++; if (o3 !== '0) begin errors++; $display("FAIL mid_reset_outs: got %h want 0", o3); end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); @(negedge clk);
            if ({b3.if_valid, b3.mem_en} !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_no_valid: %0d bad reset cycles want 0", bad); end
        next_cycle(); rst_n3 = 1'b1;
        @(negedge clk);
        checks++; if ({b3.mem_en, b3.mem_addr} !== {1'b1, 9'h005}) begin errors++; $display("FAIL mid_reissue: got en=%b a=%h want 1 005", b3.mem_en, b3.mem_addr); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); @(negedge clk);
            if ({b3.if_valid, b3.mem_en} !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_latency: %0d early cycles want 0", bad); end
        next_cycle(); @(negedge clk);
        checks++; if ({b3.if_valid, b3.if_rdata} !== {1'b1, 32'hCAFE_0005}) begin errors++; $display("FAIL mid_valid: got %b %h want 1 cafe0005", b3.if_valid, b3.if_rdata); end
        next_cycle(); idle3();
    endtask

    // Reference: one access at a time, issue at t, completion at t+LAT+1, port free again then.
    task automatic test_random();
        localparam int L = 1;
        bit busy = 0, own_dm = 0, last_dm = 0, saw_ifv = 0, saw_dmv = 0;
        int done_c = 0;
        logic [DW-1:0] exp_rd = '0;
        bit ir = 0, dr = 0, dwe = 0;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dd = '0;
        bit e_ifv, e_dmv, if_ok, dm_ok, g_if, g_dm;
        logic [42:0] e_port;
        pulse_reset1();
        for (int i = 0; i < MW; i++) begin mem1[i] = $urandom(); ref_mem[i] = mem1[i]; end
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            if (saw_ifv) ir = 0;
            if (saw_dmv) dr = 0;
            if (!ir && $urandom_range(0, 2) == 0) begin ir = 1; ia = AW'($urandom_range(0, MW - 1)); end
            if (!dr && $urandom_range(0, 2) == 0) begin
                dr = 1; da = AW'($urandom_range(0, MW - 1)); dwe = 1'($urandom_range(0, 1)); dd = $urandom();
            end
            b1.if_req = ir; b1.if_addr = ir ? ia : AW'($urandom());
            b1.dm_req = dr; b1.dm_addr = dr ? da : AW'($urandom());
            b1.dm_we = dr ? dwe : 1'b0; b1.dm_wdata = dr ? dd : $urandom();
            @(negedge clk);
            e_ifv = busy && !own_dm && c == done_c;
            e_dmv = busy && own_dm && c == done_c;
            if (busy && c == done_c) busy = 0;
            if_ok = ir && !e_ifv;
            dm_ok = dr && !e_dmv;
            g_if = 0; g_dm = 0;
            if (!busy) begin
`ifdef ARB_FAIR_EN
                if (if_ok && dm_ok) begin g_dm = !last_dm; g_if = last_dm; end
                else begin g_dm = dm_ok; g_if = if_ok; end
`else
                g_dm = dm_ok;
                g_if = if_ok && !dm_ok;
`endif
            end
            e_port = {g_if || g_dm, g_dm && dwe, g_dm ? da : (g_if ? ia : 9'h000), (g_dm && dwe) ? dd : 32'h0};
            checks++; if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== e_port)
                begin errors++; $display("FAIL rnd_port c%0d: got %h want %h", c, {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata}, e_port); end
            checks++; if ({b1.if_valid, b1.dm_valid} !== {e_ifv, e_dmv})
                begin errors++; $display("FAIL rnd_valid c%0d: got if/dm=%b want %b", c, {b1.if_valid, b1.dm_valid}, {e_ifv, e_dmv}); end
            checks++; if ({b1.stall_if, b1.stall_mem} !== {ir && !e_ifv, dr && !e_dmv})
                begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {b1.stall_if, b1.stall_mem}, {ir && !e_ifv, dr && !e_dmv}); end
            if (e_ifv) begin
                checks++; if (b1.if_rdata !== exp_rd) begin errors++; $display("FAIL rnd_if_rdata c%0d: got %h want %h", c, b1.if_rdata, exp_rd); end
            end
            if (e_dmv) begin
                checks++; if (b1.dm_rdata !== exp_rd) begin errors++; $display("FAIL rnd_dm_rdata c%0d: got %h want %h", c, b1.dm_rdata, exp_rd); end
            end
            if (g_if || g_dm) begin
                busy = 1; own_dm = g_dm; last_dm = g_dm; done_c = c + L + 1;
                if (g_dm && dwe) begin ref_mem[da] = dd; exp_rd = '0; end
                else exp_rd = ref_mem[g_dm ? da : ia];
            end
            saw_ifv = b1.if_valid; saw_dmv = b1.dm_valid;
        end
        next_cycle(); idle1();
    endtask

    initial begin
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        idle1(); idle3();
        for (int i = 0; i < MW; i++) begin mem1[i] = '0; mem3[i] = '0; ref_mem[i] = '0; end
        test_reset();
        test_fetch();
        test_write();
        test_both_fixed();
        test_grant_order();
        test_fresh_tie();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
